// File: rtl/bdd_walk_engine.sv
`default_nettype none
// ============================================================================
// Module   : bdd_walk_engine
// Brief    : Runtime-loaded multi-output BDD evaluator, walks one node per cycle.
// Revision : 1.0
// ============================================================================
module bdd_walk_engine #(
  parameter  int IN_W      = 1894,
  parameter  int VAR_W     = 11,
  parameter  int NODE_W    = 7,
  parameter  int N_OUT     = 4,
  parameter  int MAX_STEPS = 255,
  localparam int SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int PTR_W     = NODE_W + 2,
  localparam int ENT_W     = VAR_W + 2 * PTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_addr,
  input  logic [ENT_W-1:0]  cfg_wdata,
  input  logic              root_we,
  input  logic [SEL_W-1:0]  root_sel,
  input  logic [PTR_W-1:0]  root_wdata,
  input  logic [IN_W-1:0]   i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_OUT-1:0]  o,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              err,
  input  logic              err_clr
);

  localparam int                  c_DEPTH     = 2 ** NODE_W;
  localparam int                  c_STEP_W    = $clog2(MAX_STEPS + 1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(MAX_STEPS - 1);
  localparam logic [VAR_W:0]      c_VAR_LIM   = (VAR_W + 1)'(IN_W);
  localparam logic [SEL_W-1:0]    c_CH_LAST   = SEL_W'(N_OUT - 1);
  // Pointer {comp, term, idx}: reset roots are uncomplemented terminal 0
  localparam logic [PTR_W-1:0]    c_ROOT_RST  = {1'b0, 1'b1, {NODE_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;

  logic [ENT_W-1:0]     r_node [c_DEPTH];
  logic [PTR_W-1:0]     r_root [N_OUT];
  logic [IN_W-1:0]      r_vec;
  logic [PTR_W-1:0]     r_ptr;
  logic                 r_inv;
  logic [c_STEP_W-1:0]  r_steps;
  logic [SEL_W-1:0]     r_ch;
  logic [N_OUT-1:0]     r_res;
  logic [N_OUT-1:0]     r_o;
  logic                 r_err;

  logic [ENT_W-1:0]     w_ent;
  logic [VAR_W-1:0]     w_var;
  logic                 w_var_ok;
  logic                 w_bit;
  logic [PTR_W-1:0]     w_nxt;
  logic                 w_term;
  logic                 w_timeout;
  logic                 w_ch_done;
  logic                 w_last_ch;
  logic [SEL_W-1:0]     w_ch_nx;
  logic [N_OUT-1:0]     w_res;
  logic                 w_err_ev;

  always_comb begin
    w_ent      = r_node[r_ptr[NODE_W-1:0]];
    w_var      = w_ent[ENT_W-1 -: VAR_W];
    w_var_ok   = ({1'b0, w_var} < c_VAR_LIM);
    w_bit      = w_var_ok ? r_vec[w_var] : 1'b0;
    w_nxt      = w_bit ? w_ent[2*PTR_W-1 -: PTR_W] : w_ent[PTR_W-1:0];
    w_term     = r_ptr[NODE_W];
    // The step that would exhaust the budget and still land on a node ends the channel
    w_timeout  = ~w_term & (r_steps == c_STEP_LAST) & ~w_nxt[NODE_W];
    w_ch_done  = w_term | w_timeout;
    w_last_ch  = (r_ch == c_CH_LAST);
    w_ch_nx    = r_ch + SEL_W'(1);
    w_res      = r_res;
    w_res[r_ch] = w_term & (r_ptr[0] ^ r_inv);
    w_err_ev   = ((r_state != S_IDLE) & (cfg_we | root_we)) |
                 ((r_state == S_WALK) & ~w_term & (~w_var_ok | w_timeout));

    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)              w_state_nx = S_WALK;
      S_WALK:  if (w_ch_done & w_last_ch) w_state_nx = S_OUT;
      S_OUT:   if (o_ready)               w_state_nx = S_IDLE;
      default:                            w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_DEPTH; k++) r_node[k] <= '0;
      for (int k = 0; k < N_OUT; k++)   r_root[k] <= c_ROOT_RST;
    end else if (r_state == S_IDLE) begin
      if (cfg_we)  r_node[cfg_addr] <= cfg_wdata;
      if (root_we) r_root[root_sel] <= root_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_ptr   <= '0;
      r_inv   <= 1'b0;
      r_steps <= '0;
      r_ch    <= '0;
      r_res   <= '0;
      r_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_vec   <= i;
            r_ch    <= '0;
            r_ptr   <= r_root[0];
            r_inv   <= r_root[0][NODE_W+1];
            r_steps <= '0;
          end
        end
        S_WALK: begin
          if (w_ch_done) begin
            r_res <= w_res;
            if (w_last_ch) begin
              r_o <= w_res;
            end else begin
              r_ch    <= w_ch_nx;
              r_ptr   <= r_root[w_ch_nx];
              r_inv   <= r_root[w_ch_nx][NODE_W+1];
              r_steps <= '0;
            end
          end else begin
            r_ptr   <= w_nxt;
            r_inv   <= r_inv ^ w_nxt[NODE_W+1];
            r_steps <= r_steps + c_STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err_ev | (r_err & ~err_clr);
  end

  assign in_ready = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_OUT);
  assign o        = r_o;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: doc/bdd_walk_engine.md
Name: bdd_walk_engine

Overview:
- Programmable, multi-output binary-decision-diagram evaluator for per-bit CPU output prediction. Generalises the fixed, synthesised single-bit decision circuits.
- A node table and per-output root pointers are loaded at runtime. A captured input vector is then evaluated by walking the diagram one node per cycle, for each of N_OUT channels in turn.
- Sits between the trace-vector source and the prediction collector, with valid/ready on both sides.

Parameters:
- IN_W, 1894, width of input vector i
- VAR_W, 11, bits of node variable index (2**VAR_W >= IN_W)
- NODE_W, 7, node address bits; table depth 2**NODE_W
- N_OUT, 4, number of output channels (one root each)
- MAX_STEPS, 255, per-channel node-visit limit before timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  node table write strobe
- cfg_addr  in  NODE_W  node index
- cfg_wdata  in  VAR_W+2*(NODE_W+2)  {var, hi_ptr, lo_ptr}
- root_we  in  1  root write strobe
- root_sel  in  clog2(N_OUT)  channel
- root_wdata  in  NODE_W+2  root pointer
- i  in  IN_W  input vector
- in_valid  in  1  vector offered
- in_ready  out  1  engine accepts vector
- o  out  N_OUT  evaluated bits
- o_valid  out  1  o is valid
- o_ready  in  1  consumer accepts o
- err  out  1  sticky error
- err_clr  in  1  clears err

Behaviour:
- Pointer format is {comp, term, idx[NODE_W-1:0]}.
  - comp: complement edge.
  - term=1: terminal, value idx[0].
- Reset (async, rst_n=0):
  - state IDLE; in_ready=1, o_valid=0, o=0, err=0.
  - All roots = terminal 0, no complement. Node table cleared to zero.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture i into vec_q; ch=0; ptr=root[0]; inv=root[0].comp; steps=0; go to WALK.
  - WALK, one cycle per step:
    - If ptr.term: res[ch]=ptr.idx[0]^inv; advance channel.
    - Else: read node[ptr.idx]; b = vec_q[var], or 0 if var>=IN_W (also set err); nxt = b ? hi : lo; inv ^= nxt.comp; ptr=nxt; steps++.
    - If steps reaches MAX_STEPS without a terminal: res[ch]=0, set err, advance channel.
    - Advance channel: ch++, load root[ch], steps=0. After ch=N_OUT-1, go to OUT.
  - OUT: o=res, o_valid=1. Hold o stable until o_ready. On o_valid&o_ready go to IDLE.
- Latency from accept to o_valid = sum over channels of (nodes visited + 1) cycles. A terminal root costs 1 cycle. The OUT register adds no extra cycle beyond entry into OUT.
- in_ready is 0 in WALK and OUT; there is no input buffering.
- Configuration:
  - cfg_we/root_we take effect only in IDLE. If asserted in WALK/OUT, the write is dropped and err is set.
  - A write in the same cycle as an accept is applied. The walk reads the new value from the next cycle.
- err:
  - Sticky. err_clr clears it.
  - If a new error event and err_clr occur in the same cycle, err=1.
- Reset mid-WALK or mid-OUT aborts the evaluation: o_valid drops, state IDLE, tables cleared.
- Node self-loop or cycle is caught only by MAX_STEPS.

Test Plan:
- Reset check: after reset, accept any vector, N_OUT=4 -> o=4'b0000 after 4 WALK cycles; err=0.
- XOR diagram:
  - Root0 -> node0 {var=71, lo=node1, hi=node1|comp}; node1 {var=1722, lo=T0, hi=T1}.
  - Vectors i[71],i[1722] = 00,01,10,11 -> o[0] = 0,1,1,0.
  - Each takes 3 cycles on ch0.
- Multi-channel complement roots: root1 = comp|node1; root2 = T1; root3 = comp|T1; i[1722]=1 -> o = {0,1,0,1} (bits 3..0).
- Timeout: node5 {var=0, lo=node5, hi=node5}, root0=node5, MAX_STEPS=255 -> o[0]=0, err=1 after 255 steps; err_clr -> err=0.
- Busy configuration: cfg_we during WALK -> table unchanged (readback via a subsequent evaluation); err=1.
- Backpressure and reset:
  - o_ready held low 10 cycles -> o and o_valid stable, in_ready=0.
  - rst_n pulsed mid-WALK -> o_valid=0, in_ready=1 immediately, next evaluation returns all zeros.
